// File: rtl/sd_frame_ctrl.sv
// Frame controller for the serial sequence detector: clears the detector, serializes
// handshaked words MSB-first onto its input, and counts rising edges of its output.
module sd_frame_ctrl #(
    parameter int   DATA_W    = 8,
    parameter int   LEN_W     = 8,
    parameter int   CNT_W     = 8,
    parameter int   CLR_CYC   = 2,
    parameter int   DRAIN_CYC = 2,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              seq_out,
    output logic              det_clear,
    input  logic              det_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic              overflow,
    output logic              underrun
);

    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CYC_MAX = (CLR_CYC > DRAIN_CYC) ? CLR_CYC : DRAIN_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t            state_reg, state_next;
    logic              seq_reg, seq_next;
    logic              clr_reg, clr_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [CNT_W-1:0]  hit_reg, hit_next;
    logic              ovf_reg, ovf_next;
    logic              unr_reg, unr_next;
    logic [LEN_W-1:0]  words_left_reg, words_left_next;
    logic              det_prev_reg, det_prev_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic [BIT_W-1:0]  bitcnt_reg, bitcnt_next;
    logic [CYC_W-1:0]  cyc_reg, cyc_next;
    logic              first_reg, first_next;
    logic              in_ready_c, accept, count_en;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            seq_reg        <= IDLE_BIT;
            clr_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            hit_reg        <= '0;
            ovf_reg        <= 1'b0;
            unr_reg        <= 1'b0;
            words_left_reg <= '0;
            det_prev_reg   <= 1'b0;
            shreg_reg      <= '0;
            bitcnt_reg     <= '0;
            cyc_reg        <= '0;
            first_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            seq_reg        <= seq_next;
            clr_reg        <= clr_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            hit_reg        <= hit_next;
            ovf_reg        <= ovf_next;
            unr_reg        <= unr_next;
            words_left_reg <= words_left_next;
            det_prev_reg   <= det_prev_next;
            shreg_reg      <= shreg_next;
            bitcnt_reg     <= bitcnt_next;
            cyc_reg        <= cyc_next;
            first_reg      <= first_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        seq_next        = seq_reg;
        clr_next        = clr_reg;
        busy_next       = busy_reg;
        done_next       = done_reg;
        hit_next        = hit_reg;
        ovf_next        = ovf_reg;
        unr_next        = unr_reg;
        words_left_next = words_left_reg;
        det_prev_next   = det_in;
        shreg_next      = shreg_reg;
        bitcnt_next     = bitcnt_reg;
        cyc_next        = cyc_reg;
        first_next      = first_reg;
        in_ready_c      = 1'b0;
        accept          = 1'b0;
        count_en        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    hit_next = '0;
                    ovf_next = 1'b0;
                    unr_next = 1'b0;
                    if (frame_len != '0) begin
                        words_left_next = frame_len;
                        busy_next       = 1'b1;
                        clr_next        = 1'b1;
                        seq_next        = IDLE_BIT;
                        cyc_next        = CYC_W'(CLR_CYC - 1);
                        state_next      = S_CLEAR;
                    end else begin
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                seq_next      = IDLE_BIT;
                det_prev_next = 1'b0;
                if (cyc_reg == '0) begin
                    clr_next   = 1'b0;
                    first_next = 1'b1;
                    state_next = S_LOAD;
                end else begin
                    cyc_next = cyc_reg - CYC_W'(1);
                end
            end
            S_LOAD: begin
                in_ready_c = 1'b1;
                count_en   = !first_reg;
                if (in_valid) begin
                    accept = 1'b1;
                end else begin
                    seq_next = IDLE_BIT;
                    // The first word may arrive late without it counting as a stall.
                    if (!first_reg) unr_next = 1'b1;
                end
            end
            S_SHIFT: begin
                count_en = 1'b1;
                if (bitcnt_reg != '0) begin
                    seq_next    = shreg_reg[DATA_W-1];
                    shreg_next  = shreg_reg << 1;
                    bitcnt_next = bitcnt_reg - BIT_W'(1);
                end else begin
                    // Last-bit cycle: accepting here keeps the bit stream gap-free.
                    in_ready_c = (words_left_reg != '0);
                    if (in_ready_c && in_valid) begin
                        accept = 1'b1;
                    end else begin
                        seq_next = IDLE_BIT;
                        if (words_left_reg != '0) begin
                            state_next = S_LOAD;
                        end else begin
                            cyc_next   = CYC_W'(DRAIN_CYC - 1);
                            state_next = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                count_en = 1'b1;
                seq_next = IDLE_BIT;
                if (cyc_reg == '0) begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = S_DONE;
                end else begin
                    cyc_next = cyc_reg - CYC_W'(1);
                end
            end
            S_DONE: begin
                done_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        if (accept) begin
            shreg_next      = in_data << 1;
            seq_next        = in_data[DATA_W-1];
            bitcnt_next     = BIT_W'(DATA_W - 1);
            words_left_next = words_left_reg - LEN_W'(1);
            first_next      = 1'b0;
            state_next      = S_SHIFT;
        end

        // Count rising edges only; a saturated counter flags overflow instead.
        if (count_en && det_in && !det_prev_reg) begin
            if (hit_reg == '1) ovf_next = 1'b1;
            else               hit_next = hit_reg + CNT_W'(1);
        end
    end

    assign in_ready  = in_ready_c;
    assign seq_out   = seq_reg;
    assign det_clear = clr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign hit_count = hit_reg;
    assign overflow  = ovf_reg;
    assign underrun  = unr_reg;

endmodule

// File: tb/tb_sd_frame_ctrl.sv
// Scoreboard bench for sd_frame_ctrl: each start pushes the expected frame outcome,
// and a monitor captures the serial stream and status and compares on done.
module tb_sd_frame_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'd0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       det_in = 1'b0;
    logic       in_ready, seq_out, det_clear, busy, done, overflow, underrun;
    logic [1:0] hit_count;

    sd_frame_ctrl #(.DATA_W(8), .LEN_W(8), .CNT_W(2), .CLR_CYC(2), .DRAIN_CYC(2), .IDLE_BIT(1'b0)) dut (
        .clock(clock), .reset(reset), .start(start), .frame_len(frame_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .seq_out(seq_out), .det_clear(det_clear), .det_in(det_in),
        .busy(busy), .done(done), .hit_count(hit_count),
        .overflow(overflow), .underrun(underrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] stream;
        int len, hits, ovf, unr, clr, rdy;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   frames_seen = 0;

    // Word source and detector stimulus shared with the driver processes
    logic [7:0]   wbuf [0:7];
    int           gbuf [0:7];
    int           n_words = 0;
    int           widx = 0;
    int           gap_left = 0;
    bit           drv_active = 1'b0;
    logic [127:0] det_sched = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic e_new(input int clr);
        cur.stream = '0;
        cur.len = 0; cur.hits = 0; cur.ovf = 0; cur.unr = 0; cur.clr = clr; cur.rdy = 0;
    endtask

    task automatic e_idle(input int n);
        for (int i = 0; i < n; i++) begin
            cur.stream[cur.len] = 1'b0;
            cur.len++;
        end
    endtask

    task automatic e_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) begin
            cur.stream[cur.len] = w[i];
            cur.len++;
        end
    endtask

    task automatic set_words(input int n, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input int g1);
        wbuf[0] = w0; wbuf[1] = w1; wbuf[2] = w2;
        gbuf[0] = 0;  gbuf[1] = g1; gbuf[2] = 0;
        n_words = n; widx = 0; gap_left = 0;
        drv_active = 1'b1;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_seen < target && n < 400) begin
            @(negedge clock);
            n++;
        end
        if (frames_seen < target) chk("frame_timeout", frames_seen, target);
    endtask

    task automatic run_frame(input int len, input bit poke_busy);
        int target;
        target = frames_seen + 1;
        @(negedge clock);
        start = 1'b1;
        frame_len = len[7:0];
        exp_q.push_back(cur);
        @(negedge clock);
        start = 1'b0;
        if (poke_busy) begin
            repeat (8) @(negedge clock);
            start = 1'b1;
            frame_len = 8'd5;
            @(negedge clock);
            start = 1'b0;
            frame_len = 8'd0;
        end
        wait_frames(target);
        drv_active = 1'b0;
    endtask

    // Word source: holds off for the requested number of offered ready cycles, then presents
    initial begin
        forever begin
            @(negedge clock);
            if (drv_active && widx < n_words) begin
                if (gap_left > 0) begin
                    in_valid = 1'b0;
                    if (in_ready) gap_left--;
                end else begin
                    in_valid = 1'b1;
                    in_data  = wbuf[widx];
                    if (in_ready) begin
                        widx++;
                        gap_left = (widx < n_words) ? gbuf[widx] : 0;
                    end
                end
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    // Detector model: plays det_sched indexed by cycle since the clear phase ended
    initial begin
        int di;
        di = 0;
        forever begin
            @(negedge clock);
            if (reset && busy && !det_clear && di < 128) begin
                det_in = det_sched[di];
                di++;
            end else begin
                det_in = 1'b0;
                di = 0;
            end
        end
    end

    // Monitor
    initial begin
        logic [127:0] cap;
        int   cap_len, clr_cnt, rdy_cnt;
        bit   done_prev;
        exp_t e;
        cap = '0; cap_len = 0; clr_cnt = 0; rdy_cnt = 0; done_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                cap = '0; cap_len = 0; clr_cnt = 0; rdy_cnt = 0; done_prev = 1'b0;
            end else begin
                if (det_clear) clr_cnt++;
                if (in_ready) rdy_cnt++;
                if (busy && !det_clear && cap_len < 128) begin
                    cap[cap_len] = seq_out;
                    cap_len++;
                end
                if (done) begin
                    chk("done_width", done_prev, 1'b0);
                    chk("done_expected", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("stream_len", cap_len, e.len);
                        chk("stream_bits", cap, e.stream);
                        chk("hit_count", hit_count, e.hits);
                        chk("overflow", overflow, e.ovf);
                        chk("underrun", underrun, e.unr);
                        chk("clear_cycles", clr_cnt, e.clr);
                        chk("ready_cycles", rdy_cnt, e.rdy);
                    end
                    $display("frame %0d: bits=%0d hits=%0d ovf=%0b unr=%0b clr=%0d rdy=%0d",
                             frames_seen, cap_len, hit_count, overflow, underrun, clr_cnt, rdy_cnt);
                    frames_seen++;
                    cap = '0; cap_len = 0; clr_cnt = 0; rdy_cnt = 0;
                end else if (exp_q.size() == 0) begin
                    chk("idle_quiet", {busy, det_clear, in_ready}, 3'b000);
                end
                done_prev = done;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Reset / idle
        repeat (10) @(negedge clock);
        chk("rst_seq_out", seq_out, 1'b0);
        chk("rst_det_clear", det_clear, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hit_count", hit_count, 2'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_underrun", underrun, 1'b0);
        $display("reset/idle checked");

        // Single word: load cycle, 8 bits, 2 drain cycles
        det_sched = '0;
        set_words(1, 8'hAC, 8'h00, 8'h00, 0);
        e_new(2); e_idle(1); e_word(8'hAC); e_idle(2); cur.rdy = 1;
        run_frame(1, 1'b0);

        // Back-to-back, with a start pulse while busy
        set_words(3, 8'hA5, 8'h3C, 8'h81, 0);
        e_new(2); e_idle(1); e_word(8'hA5); e_word(8'h3C); e_word(8'h81); e_idle(2); cur.rdy = 3;
        run_frame(3, 1'b1);

        // Stall of 3 refused-ready cycles between words; one hit inside the gap
        det_sched = '0; det_sched[10] = 1'b1;
        set_words(2, 8'h5A, 8'hF0, 8'h00, 3);
        e_new(2); e_idle(1); e_word(8'h5A); e_idle(3); e_word(8'hF0); e_idle(2);
        cur.rdy = 5; cur.unr = 1; cur.hits = 1;
        run_frame(2, 1'b0);

        // Counting 1,1,0,1 in SHIFT plus one in DRAIN: reaches max without overflow
        det_sched = '0;
        det_sched[2] = 1'b1; det_sched[3] = 1'b1; det_sched[5] = 1'b1; det_sched[9] = 1'b1;
        set_words(1, 8'h00, 8'h00, 8'h00, 0);
        e_new(2); e_idle(1); e_word(8'h00); e_idle(2); cur.rdy = 1; cur.hits = 3;
        run_frame(1, 1'b0);
        repeat (3) @(negedge clock);
        chk("hold_hit_count", hit_count, 2'd3);
        chk("hold_overflow", overflow, 1'b0);

        // Five pulses into a 2-bit counter: saturate and overflow
        det_sched = '0;
        det_sched[1] = 1'b1; det_sched[3] = 1'b1; det_sched[5] = 1'b1;
        det_sched[7] = 1'b1; det_sched[9] = 1'b1;
        set_words(1, 8'hFF, 8'h00, 8'h00, 0);
        e_new(2); e_idle(1); e_word(8'hFF); e_idle(2); cur.rdy = 1; cur.hits = 3; cur.ovf = 1;
        run_frame(1, 1'b0);
        repeat (2) @(negedge clock);
        chk("hold_overflow_set", overflow, 1'b1);

        // Zero-length frame: done on the next cycle, no clear, status wiped
        det_sched = '0;
        n_words = 0; drv_active = 1'b0;
        e_new(0);
        begin
            int target;
            target = frames_seen + 1;
            @(negedge clock);
            start = 1'b1;
            frame_len = 8'd0;
            exp_q.push_back(cur);
            @(negedge clock);
            start = 1'b0;
            chk("len0_done_next", done, 1'b1);
            chk("len0_busy", busy, 1'b0);
            wait_frames(target);
        end

        // Asynchronous reset in the middle of SHIFT
        det_sched = '0; det_sched[2] = 1'b1;
        set_words(2, 8'hFF, 8'hFF, 8'h00, 0);
        e_new(2);
        @(negedge clock);
        start = 1'b1;
        frame_len = 8'd2;
        exp_q.push_back(cur);
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        chk("mid_busy", busy, 1'b1);
        chk("mid_hit_count", hit_count, 2'd1);
        chk("mid_seq_out", seq_out, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("arst_seq_out", seq_out, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_det_clear", det_clear, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_hit_count", hit_count, 2'd0);
        chk("arst_overflow", overflow, 1'b0);
        chk("arst_underrun", underrun, 1'b0);
        $display("async reset mid-shift checked");
        exp_q.delete();
        drv_active = 1'b0;
        n_words = 0;
        det_sched = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // Recovery frame after reset re-clears the detector
        set_words(1, 8'h81, 8'h00, 8'h00, 0);
        e_new(2); e_idle(1); e_word(8'h81); e_idle(2); cur.rdy = 1;
        run_frame(1, 1'b0);

        repeat (5) @(negedge clock);
        chk("end_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_frame_ctrl.md
Name: sd_frame_ctrl

Overview:
- Frame controller that sequences the serial sequence detector (`sd`) datapath.
- Accepts parallel words over a valid/ready handshake, clears the detector, and serializes each word MSB-first onto the detector's `sequence_in`.
- Counts detector hits over the frame, drains detector latency, then reports completion.
- Sits between a word source (CPU/FIFO) and one `sd` instance.

Parameters:
- DATA_W, 8, bits per input word; serialized MSB-first.
- LEN_W, 8, width of frame length in words.
- CNT_W, 8, width of hit counter.
- CLR_CYC, 2, cycles `det_clear` is held high at frame start (≥1).
- DRAIN_CYC, 2, cycles spent after the last bit so late detector outputs are counted (≥1).
- IDLE_BIT, 0, value driven on `seq_out` when no data bit is being presented.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle request to begin a frame; ignored when busy=1.
- frame_len  in  LEN_W  number of words in frame; sampled when start is accepted.
- in_data  in  DATA_W  word to serialize.
- in_valid  in  1  in_data valid.
- in_ready  out  1  controller accepts in_data this cycle.
- seq_out  out  1  registered serial bit to detector `sequence_in`.
- det_clear  out  1  registered active-high reset to the detector.
- det_in  in  1  detector `detector_out`.
- busy  out  1  high from start acceptance until done.
- done  out  1  1-cycle completion pulse.
- hit_count  out  CNT_W  detections in the current/last frame.
- overflow  out  1  sticky: hit_count saturated this frame.
- underrun  out  1  sticky: word source stalled mid-frame.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - seq_out=IDLE_BIT.
  - det_clear, in_ready, busy, done, overflow and underrun all 0.
  - hit_count=0; words_left=0; det_prev=0.
- States: IDLE, CLEAR, LOAD, SHIFT, DRAIN, DONE. All outputs registered except in_ready (decoded from state/bit counter).
- IDLE:
  - On start with frame_len≠0: latch words_left=frame_len, clear hit_count, overflow and underrun, set busy=1, go to CLEAR.
  - On start with frame_len=0: clear the same status, go directly to DONE; no det_clear pulse.
- CLEAR:
  - det_clear=1 for exactly CLR_CYC cycles, seq_out=IDLE_BIT, det_prev=0; then LOAD.
- LOAD:
  - in_ready=1.
  - On in_valid & in_ready (accept edge): shreg<=in_data, seq_out<=in_data[DATA_W-1], bitcnt<=DATA_W-1, words_left--, go to SHIFT.
  - Each cycle without acceptance: seq_out=IDLE_BIT.
  - If LOAD is entered from SHIFT (i.e. not the first word) and a cycle passes without acceptance, set underrun.
- SHIFT:
  - Each edge presents the next lower bit, so every bit is on seq_out for exactly 1 cycle and a word takes DATA_W cycles.
  - in_ready=1 during the last-bit cycle (bitcnt=0) if words_left≠0; acceptance there loads the next word seamlessly, with no gap bit.
  - After the last bit with no acceptance: words_left≠0 → LOAD; words_left=0 → DRAIN.
- DRAIN:
  - DRAIN_CYC cycles with seq_out=IDLE_BIT; then DONE.
- DONE:
  - done=1 for one cycle, busy drops to 0 on the same edge; then IDLE. hit_count, overflow and underrun hold until the next accepted start.
- Hit counting:
  - Active in LOAD (non-first), SHIFT and DRAIN.
  - det_prev<=det_in each cycle.
  - Increment on a rising edge (det_in=1 & det_prev=0); a held-high det_in counts once.
  - Saturate at 2^CNT_W−1; a further rising edge sets overflow.
- start while busy: ignored, no effect.
- in_valid outside in_ready: no effect, data not consumed.
- reset mid-frame: immediate return to reset values; the detector is re-cleared on the next frame's CLEAR.

Test Plan:
- Reset/idle:
  - Stimulus: reset=0 for 3 cycles, then 1, no start.
  - Required: seq_out=0, det_clear=0, busy=0, in_ready=0, hit_count=0 indefinitely.
- Single word:
  - Stimulus: start, frame_len=1, in_data=8'b1010_1100 always valid.
  - Required: det_clear high 2 cycles; seq_out=1,0,1,0,1,1,0,0 on consecutive cycles; done exactly 8+2 cycles after the accept edge; busy low after done.
- Back-to-back:
  - Stimulus: frame_len=3, in_valid held 1.
  - Required: 24 contiguous data bits, no IDLE_BIT gaps; in_ready high only on accept cycles; underrun=0.
- Stall:
  - Stimulus: frame_len=2, in_valid dropped 3 cycles between words.
  - Required: 3 IDLE_BIT cycles between words; underrun=1; done still asserted.
- Counting:
  - Stimulus: bench drives det_in pulses 1,1,0,1 during SHIFT and one pulse in DRAIN.
  - Required: hit_count=3. With CNT_W=2 and 5 pulses: hit_count=3, overflow=1.
- Edge cases:
  - Stimulus (a): start with frame_len=0. Required: done on the next cycle, no det_clear.
  - Stimulus (b): start while busy. Required: ignored.
  - Stimulus (c): reset asserted mid-SHIFT. Required: all outputs return to reset values asynchronously.
